uart_tx_fsm: RTL and testbench

//   UART transmitter: serialises 8-bit words into start/data/stop frames on ser_out.
//   It is the transmit end of our UART link; its default bit timing matches our receiver (2 CLK per bit).
//   A one-entry holding buffer accepts the next byte while the current frame is shifting out.

---
 rtl/uart_tx_fsm.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// A one-entry holding buffer lets frames run back to back without an idle gap.
module uart_tx_fsm #(
   parameter int unsigned CLKS_PER_BIT = 2,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] par_in,
   input  logic       load,
   output logic       ready,
   output logic       ser_out,
   output logic       busy,
   output logic       tx_done
);

   localparam int unsigned CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    buf_q, buf_d;
   logic          full_q, full_d;
   logic          ser_q, ser_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ready_q, ready_d;
   logic          accept;
   logic          bit_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      buf_d   = buf_q;
      full_d  = full_q;
      done_d  = 1'b0;
      accept  = load && ready_q;
      bit_end = (cnt_q == CNT_LAST);

      if (accept) begin
         buf_d  = par_in;
         full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (full_q) begin
               state_d = S_START;
               shift_d = buf_q;
               full_d  = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            // bit_q counts stop bits here; a pending byte starts its frame with no idle cycle
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  if (full_q) begin
                     state_d = S_START;
                     shift_d = buf_q;
                     full_d  = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it
      ready_d = ~full_d;
      busy_d  = (state_d != S_IDLE);
      case (state_d)
         S_START: ser_d = 1'b0;
         S_DATA:  ser_d = shift_d[0];
         default: ser_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         buf_q   <= '0;
         full_q  <= 1'b0;
         ser_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         buf_q   <= buf_d;
         full_q  <= full_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign ready   = ready_q;
   assign ser_out = ser_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm: default timing instance plus a
// CLKS_PER_BIT=3 / STOP_BITS=2 instance.
module tb_uart_tx_fsm;

   logic       CLK;
   logic       RST;
   logic [7:0] par_in, par_in6;
   logic       load, load6;
   logic       ready, ser_out, busy, tx_done;
   logic       ready6, ser_out6, busy6, tx_done6;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_fsm u_dut (
      .CLK     (CLK),
      .RST     (RST),
      .par_in  (par_in),
      .load    (load),
      .ready   (ready),
      .ser_out (ser_out),
      .busy    (busy),
      .tx_done (tx_done)
   );

   uart_tx_fsm #(
      .CLKS_PER_BIT (3),
      .STOP_BITS    (2)
   ) u_dut6 (
      .CLK     (CLK),
      .RST     (RST),
      .par_in  (par_in6),
      .load    (load6),
      .ready   (ready6),
      .ser_out (ser_out6),
      .busy    (busy6),
      .tx_done (tx_done6)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Samples n cycles of ser_out (first sample ends up most significant) and
   // tx_done over n+1 samples; optionally issues up to two one-cycle loads.
   task automatic capture(input int n, input int la1, input logic [7:0] b1,
                          input int la2, input logic [7:0] b2,
                          output logic [63:0] ser, output int np,
                          output int p1, output int p2, output logic rdy_la2);
      ser = '0; np = 0; p1 = -1; p2 = -1; rdy_la2 = 1'bx;
      for (int i = 0; i <= n; i++) begin
         if (i < n) ser = {ser[62:0], ser_out};
         if (tx_done) begin
            if (np == 0) p1 = i; else if (np == 1) p2 = i;
            np++;
         end
         if (i < n) begin
            if (i == la1) begin par_in = b1; load = 1'b1; end
            if (i == la2) begin rdy_la2 = ready; par_in = b2; load = 1'b1; end
            tick();
            load = 1'b0;
         end
      end
   endtask

   // Accepts a byte while idle and advances to the first START cycle
   task automatic start_byte(input logic [7:0] b);
      par_in = b;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      tick();
   endtask

   logic [63:0] ser;
   logic [32:0] ser6;
   int          np, p1, p2;
   logic        rdy;
   logic        any_hi, any_lo;
   int          done6_at;

   initial begin
      RST = 1'b1; load = 1'b1; par_in = 8'h55; load6 = 1'b0; par_in6 = 8'h00;

      // T1: reset held with load asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_ser", ser_out, 1'b1);
         check("t1_ready", ready, 1'b1);
         check("t1_busy", busy, 1'b0);
         check("t1_done", tx_done, 1'b0);
      end
      RST = 1'b0; load = 1'b0;
      tick();
      tick();
      check("t1_nostart_busy", busy, 1'b0);
      check("t1_nostart_ser", ser_out, 1'b1);
      check("t1_ready6", ready6, 1'b1);

      // T2: single 0xA5
      par_in = 8'hA5; load = 1'b1;
      tick();
      load = 1'b0;
      check("t2_ready_after_accept", ready, 1'b0);
      check("t2_ser_idle", ser_out, 1'b1);
      tick();
      check("t2_ready_at_start", ready, 1'b1);
      check("t2_busy_start", busy, 1'b1);
      capture(20, -1, 8'h00, -1, 8'h00, ser, np, p1, p2, rdy);
      check("t2_frame", ser[19:0], 20'b00110011000011001111);
      check("t2_done_count", np, 1);
      check("t2_done_at", p1, 20);
      check("t2_busy_end", busy, 1'b0);
      tick();
      check("t2_done_width", tx_done, 1'b0);

      // T3: 0x00 then 0xFF back to back
      tick();
      start_byte(8'h00);
      capture(40, 2, 8'hFF, -1, 8'h00, ser, np, p1, p2, rdy);
      check("t3_frames", ser[39:0],
            {20'b00000000000000000011, 20'b00111111111111111111});
      check("t3_done_count", np, 2);
      check("t3_done1", p1, 20);
      check("t3_done2", p2, 40);
      check("t3_busy_end", busy, 1'b0);

      // T4: third load while buffer full is dropped
      tick();
      start_byte(8'h11);
      capture(40, 2, 8'h22, 5, 8'h33, ser, np, p1, p2, rdy);
      check("t4_ready_when_full", rdy, 1'b0);
      check("t4_frames", ser[39:0],
            {20'b00110000001100000011, 20'b00001100000011000011});
      check("t4_done_count", np, 2);
      any_lo = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ser_out == 1'b0 || busy) any_lo = 1'b1;
      end
      check("t4_no_third_frame", any_lo, 1'b0);
      check("t4_ready_end", ready, 1'b1);

      // T5: reset 7 cycles into a 0x5A frame, with 0x77 pending in the buffer
      start_byte(8'h5A);
      for (int i = 0; i < 7; i++) begin
         if (i == 3) begin par_in = 8'h77; load = 1'b1; end
         tick();
         load = 1'b0;
      end
      check("t5_ready_pending", ready, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t5_ser_after_rst", ser_out, 1'b1);
      check("t5_ready_after_rst", ready, 1'b1);
      check("t5_busy_after_rst", busy, 1'b0);
      any_hi = 1'b0; any_lo = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (tx_done) any_hi = 1'b1;
         if (ser_out == 1'b0) any_lo = 1'b1;
         tick();
      end
      check("t5_no_done", any_hi, 1'b0);
      check("t5_buffer_discarded", any_lo, 1'b0);
      start_byte(8'h3C);
      capture(20, -1, 8'h00, -1, 8'h00, ser, np, p1, p2, rdy);
      check("t5_frame_3c", ser[19:0], 20'b00000011111111000011);
      check("t5_done_at", p1, 20);

      // T6: 3 clocks per bit, 2 stop bits, byte 0x81
      par_in6 = 8'h81; load6 = 1'b1;
      tick();
      load6 = 1'b0;
      tick();
      ser6 = '0; done6_at = -1;
      for (int i = 0; i <= 33; i++) begin
         if (i < 33) ser6 = {ser6[31:0], ser_out6};
         if (tx_done6 && done6_at < 0) done6_at = i;
         if (i < 33) tick();
      end
      check("t6_frame", ser6, 33'b000_111_000000000000000000_111_111_111);
      check("t6_done_at", done6_at, 33);
      check("t6_busy_end", busy6, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
